// File: rtl/accum_stream_driver_if.sv
// accum_stream_driver_if
//   Groups every non-clock, non-reset signal of accum_stream_driver.
//   master : the driver's view (drives commands ready, beats, status).
//   slave  : the surrounding system's view (buffer writer, command source,
//            accumulator result path).
//   Signals:
//     wrEnIn / wrAddrIn / wrDataIn   sample-buffer write port
//     cmdValidIn / cmdLenIn          run request and vector length
//     cmdReadyOut                    driver idle, able to take a command
//     startOut / lastOut / validOut  beat framing toward the accumulator
//     dataOut                        beat sample toward the accumulator
//     resValidIn / resDataIn         accumulator result return
//     resultOut                      last captured sum
//     busyOut / doneOut / errOut     status
interface accum_stream_driver_if;
  logic        wrEnIn;
  logic [7:0]  wrAddrIn;
  logic [31:0] wrDataIn;
  logic        cmdValidIn;
  logic [8:0]  cmdLenIn;
  logic        cmdReadyOut;
  logic        startOut;
  logic        lastOut;
  logic        validOut;
  logic [31:0] dataOut;
  logic        resValidIn;
  logic [31:0] resDataIn;
  logic [31:0] resultOut;
  logic        busyOut;
  logic        doneOut;
  logic        errOut;

  modport master (
    input  wrEnIn, wrAddrIn, wrDataIn, cmdValidIn, cmdLenIn, resValidIn, resDataIn,
    output cmdReadyOut, startOut, lastOut, validOut, dataOut, resultOut,
           busyOut, doneOut, errOut
  );

  modport slave (
    output wrEnIn, wrAddrIn, wrDataIn, cmdValidIn, cmdLenIn, resValidIn, resDataIn,
    input  cmdReadyOut, startOut, lastOut, validOut, dataOut, resultOut,
           busyOut, doneOut, errOut
  );
endinterface

// File: rtl/accum_stream_driver.sv
// accum_stream_driver
//   Holds a DEPTH x 32 buffer of float32 samples. On a run command of length
//   N it streams buffer[0..N-1] as a contiguous frame of beats to an external
//   accumulator, then waits for the accumulator's result, captures it and
//   pulses doneOut. Illegal lengths and result timeouts pulse errOut.
//   Ports:
//     clkIn  : clock, all state on the rising edge
//     rstIn  : asynchronous active-low reset
//     bus    : accum_stream_driver_if master modport (buffer write, command,
//              beat stream, result return, status)
//   Parameters:
//     DEPTH          : buffer entries and maximum vector length
//     TIMEOUT_CYCLES : WAIT cycles allowed before a timeout error
module accum_stream_driver #(
  parameter int DEPTH          = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  accum_stream_driver_if.master   bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT} stateT;

  stateT         state;
  stateT         nextState;
  logic [8:0]    lenReg;
  logic [8:0]    rdIdx;
  logic [CW-1:0] waitCnt;

  logic          acceptCmd;
  logic          badLen;
  logic          issueRead;
  logic          capture;
  logic          timeout;

  logic          readyReg;
  logic          beatValid;
  logic          beatStart;
  logic          beatLast;
  logic [31:0]   readData;
  logic [31:0]   resultReg;
  logic          doneReg;
  logic          errReg;

  logic [31:0]   mem [DEPTH];

  // State register.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and per-cycle control strobes. Acceptance is qualified by the
  // registered ready flag so nothing is taken on the edge that releases reset.
  // STREAM issues one buffer read per cycle while reads remain, then spends
  // one more cycle so the final read can emerge as the last beat before WAIT.
  // In WAIT a result arriving on the timeout cycle takes priority.
  always_comb begin
    nextState = state;
    acceptCmd = 1'b0;
    badLen    = 1'b0;
    issueRead = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmdValidIn && readyReg) begin
          acceptCmd = 1'b1;
          if (bus.cmdLenIn == 9'd0 || int'(bus.cmdLenIn) > DEPTH) badLen = 1'b1;
          else nextState = STREAM;
        end
      end
      STREAM: begin
        if (rdIdx < lenReg) issueRead = 1'b1;
        else                nextState = WAIT;
      end
      WAIT: begin
        if (bus.resValidIn) begin
          capture   = 1'b1;
          nextState = IDLE;
        end else if (waitCnt == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Length latch, beat index and WAIT cycle counter. The wait counter is held
  // at zero outside WAIT so it always starts from zero on entry.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      lenReg  <= '0;
      rdIdx   <= '0;
      waitCnt <= '0;
    end else begin
      if (acceptCmd) begin
        lenReg <= bus.cmdLenIn;
        rdIdx  <= '0;
      end else if (issueRead) begin
        rdIdx <= rdIdx + 9'd1;
      end
      if (state == WAIT) waitCnt <= waitCnt + 1'b1;
      else               waitCnt <= '0;
    end
  end

  // Sample buffer: written only while idle, read every cycle at the beat
  // index. The read result is only exposed when a beat is valid.
  always_ff @(posedge clkIn) begin
    if (bus.wrEnIn && state == IDLE) mem[bus.wrAddrIn] <= bus.wrDataIn;
    readData <= mem[rdIdx[7:0]];
  end

  // Beat framing, aligned with the one-cycle buffer read latency.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      beatValid <= 1'b0;
      beatStart <= 1'b0;
      beatLast  <= 1'b0;
    end else begin
      beatValid <= issueRead;
      beatStart <= issueRead && (rdIdx == 9'd0);
      beatLast  <= issueRead && (rdIdx == lenReg - 9'd1);
    end
  end

  // Status and result registers. Ready mirrors "next cycle is IDLE" so it
  // stays low throughout reset and rises on the first edge after release.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      readyReg  <= 1'b0;
      doneReg   <= 1'b0;
      errReg    <= 1'b0;
      resultReg <= '0;
    end else begin
      readyReg <= (nextState == IDLE);
      doneReg  <= capture;
      errReg   <= badLen || timeout;
      if (capture) resultReg <= bus.resDataIn;
    end
  end

  assign bus.cmdReadyOut = readyReg;
  assign bus.startOut    = beatStart;
  assign bus.lastOut     = beatLast;
  assign bus.validOut    = beatValid;
  assign bus.dataOut     = beatValid ? readData : 32'h0;
  assign bus.resultOut   = resultReg;
  assign bus.busyOut     = (state != IDLE);
  assign bus.doneOut     = doneReg;
  assign bus.errOut      = errReg;

endmodule

// File: tb/tb_accum_stream_driver.sv
// tb_accum_stream_driver
//   Directed + randomized bench for accum_stream_driver. A behavioural model
//   (sample array, expected result) predicts every beat and status pulse
//   from the frame rules: beat i of N carries buffer[i], start on beat 0,
//   last on beat N-1, result captured only in WAIT, timeout after
//   TIMEOUT_CYCLES WAIT cycles.
module tb_accum_stream_driver;
  localparam int DEPTH = 256;
  localparam int TO    = 64;

  logic clkIn = 1'b0;
  logic rstIn;

  accum_stream_driver_if bus();

  accum_stream_driver #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clkIn(clkIn),
    .rstIn(rstIn),
    .bus  (bus)
  );

  always #5 clkIn = ~clkIn;

  logic [31:0] model [DEPTH];
  logic [31:0] expResult;
  int checkCount = 0;
  int passCount  = 0;

  // Advance one clock and settle just past the rising edge.
  task automatic tick;
    @(posedge clkIn);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] intToFloat(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic writeBuf(input int addr, input logic [31:0] data);
    bus.wrEnIn   = 1'b1;
    bus.wrAddrIn = 8'(addr);
    bus.wrDataIn = data;
    tick;
    bus.wrEnIn   = 1'b0;
    model[addr]  = data;
  endtask

  // Illegal length: one errOut pulse, no beat, stays idle.
  task automatic badCommand(input int n);
    bus.cmdLenIn   = 9'(n);
    bus.cmdValidIn = 1'b1;
    tick;
    bus.cmdValidIn = 1'b0;
    checkOutput($sformatf("badErr%0d", n), bus.errOut, 1);
    checkOutput($sformatf("badDone%0d", n), bus.doneOut, 0);
    checkOutput($sformatf("badValid%0d", n), bus.validOut, 0);
    checkOutput($sformatf("badReady%0d", n), bus.cmdReadyOut, 1);
    checkOutput($sformatf("badBusy%0d", n), bus.busyOut, 0);
    tick;
    checkOutput($sformatf("badErrEnd%0d", n), bus.errOut, 0);
    checkOutput($sformatf("badValid2_%0d", n), bus.validOut, 0);
  endtask

  // One complete frame of length n. respDelay < 0 lets the WAIT time out,
  // otherwise the result is returned in WAIT cycle respDelay.
  task automatic applyStimulus(input int n, input int respDelay,
                               input logic [31:0] respData, input bit midWrite);
    bit sawPulse;
    bus.cmdLenIn   = 9'(n);
    bus.cmdValidIn = 1'b1;
    tick;
    bus.cmdValidIn = 1'b0;
    checkOutput("streamBusy", bus.busyOut, 1);
    checkOutput("streamReady", bus.cmdReadyOut, 0);
    checkOutput("preBeatValid", bus.validOut, 0);
    checkOutput("preBeatData", bus.dataOut, 0);
    for (int i = 0; i < n; i++) begin
      bus.resValidIn = 1'($urandom_range(0, 1));
      bus.resDataIn  = $urandom;
      if (midWrite && i == 10) begin
        bus.wrEnIn   = 1'b1;
        bus.wrAddrIn = 8'd200;
        bus.wrDataIn = ~model[200];
      end
      tick;
      bus.wrEnIn = 1'b0;
      checkOutput($sformatf("beatValid%0d", i), bus.validOut, 1);
      checkOutput($sformatf("beatStart%0d", i), bus.startOut, (i == 0) ? 1 : 0);
      checkOutput($sformatf("beatLast%0d", i), bus.lastOut, (i == n - 1) ? 1 : 0);
      checkOutput($sformatf("beatData%0d", i), bus.dataOut, model[i]);
    end
    bus.resValidIn = 1'b0;
    tick;
    checkOutput("waitValid", bus.validOut, 0);
    checkOutput("waitStart", bus.startOut, 0);
    checkOutput("waitLast", bus.lastOut, 0);
    checkOutput("waitData", bus.dataOut, 0);
    checkOutput("waitBusy", bus.busyOut, 1);
    checkOutput("waitResultHeld", bus.resultOut, expResult);
    checkOutput("waitNoDone", bus.doneOut, 0);
    sawPulse = 1'b0;
    if (respDelay < 0) begin
      for (int j = 1; j < TO; j++) begin
        tick;
        sawPulse |= bus.doneOut | bus.errOut | bus.validOut;
      end
      checkOutput("noEarlyPulse", 32'(sawPulse), 0);
      tick;
      checkOutput("toErr", bus.errOut, 1);
      checkOutput("toDone", bus.doneOut, 0);
      checkOutput("toResult", bus.resultOut, expResult);
      checkOutput("toBusy", bus.busyOut, 0);
      checkOutput("toReady", bus.cmdReadyOut, 1);
    end else begin
      for (int j = 1; j <= respDelay; j++) begin
        tick;
        sawPulse |= bus.doneOut | bus.errOut | bus.validOut;
      end
      checkOutput("noEarlyPulse", 32'(sawPulse), 0);
      bus.resValidIn = 1'b1;
      bus.resDataIn  = respData;
      tick;
      bus.resValidIn = 1'b0;
      bus.resDataIn  = $urandom;
      expResult      = respData;
      checkOutput("capDone", bus.doneOut, 1);
      checkOutput("capErr", bus.errOut, 0);
      checkOutput("capResult", bus.resultOut, expResult);
      checkOutput("capBusy", bus.busyOut, 0);
      checkOutput("capReady", bus.cmdReadyOut, 1);
    end
    tick;
    checkOutput("pulseEndDone", bus.doneOut, 0);
    checkOutput("pulseEndErr", bus.errOut, 0);
    checkOutput("idleResult", bus.resultOut, expResult);
  endtask

  initial begin
    bus.wrEnIn     = 1'b0;
    bus.wrAddrIn   = '0;
    bus.wrDataIn   = '0;
    bus.cmdValidIn = 1'b0;
    bus.cmdLenIn   = '0;
    bus.resValidIn = 1'b0;
    bus.resDataIn  = '0;
    expResult      = 32'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Reset state, before any clock edge.
    rstIn = 1'b0;
    #3;
    checkOutput("rstReady", bus.cmdReadyOut, 0);
    checkOutput("rstValid", bus.validOut, 0);
    checkOutput("rstBusy", bus.busyOut, 0);
    checkOutput("rstDone", bus.doneOut, 0);
    checkOutput("rstErr", bus.errOut, 0);
    checkOutput("rstData", bus.dataOut, 0);
    checkOutput("rstResult", bus.resultOut, 0);
    tick;
    tick;
    checkOutput("rstReadyHeld", bus.cmdReadyOut, 0);
    rstIn = 1'b1;
    tick;
    checkOutput("readyAfterRst", bus.cmdReadyOut, 1);

    // Four-sample frame with a fixed accumulator answer.
    writeBuf(0, 32'h3F800000);
    writeBuf(1, 32'h40000000);
    writeBuf(2, 32'h40400000);
    writeBuf(3, 32'h40800000);
    applyStimulus(4, 2, 32'h41200000, 1'b0);

    // Single-beat frame.
    applyStimulus(1, 0, $urandom, 1'b0);

    // Illegal lengths.
    badCommand(0);
    badCommand(257);
    badCommand($urandom_range(258, 511));

    // Timeout, then result arriving exactly on the timeout cycle.
    applyStimulus(2, -1, 32'h0, 1'b0);
    applyStimulus(2, TO - 1, $urandom, 1'b0);

    // Full-depth frame of integer floats, with an ignored mid-stream write.
    for (int i = 0; i < DEPTH; i++) writeBuf(i, intToFloat(i));
    applyStimulus(DEPTH, $urandom_range(0, 5), $urandom, 1'b1);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int k = 0; k < 8; k++) writeBuf($urandom_range(0, n - 1), $urandom);
      applyStimulus(n, $urandom_range(0, 10), $urandom, 1'b0);
    end

    // Reset during beat 3 of an eight-beat frame.
    for (int i = 0; i < 8; i++) writeBuf(i, $urandom);
    bus.cmdLenIn   = 9'd8;
    bus.cmdValidIn = 1'b1;
    tick;
    bus.cmdValidIn = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    checkOutput("abortBeat3Data", bus.dataOut, model[3]);
    rstIn = 1'b0;
    #1;
    checkOutput("abortValid", bus.validOut, 0);
    checkOutput("abortStart", bus.startOut, 0);
    checkOutput("abortLast", bus.lastOut, 0);
    checkOutput("abortData", bus.dataOut, 0);
    checkOutput("abortBusy", bus.busyOut, 0);
    checkOutput("abortReady", bus.cmdReadyOut, 0);
    checkOutput("abortResult", bus.resultOut, 0);
    checkOutput("abortDone", bus.doneOut, 0);
    checkOutput("abortErr", bus.errOut, 0);
    expResult = 32'h0;
    tick;
    checkOutput("abortValidLater", bus.validOut, 0);
    tick;
    rstIn = 1'b1;
    tick;
    checkOutput("abortReadyBack", bus.cmdReadyOut, 1);
    checkOutput("abortNoBeat", bus.validOut, 0);
    for (int i = 0; i < 8; i++) writeBuf(i, $urandom);
    applyStimulus(8, $urandom_range(0, 6), $urandom, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
